// File: rtl/memory_responder.sv
`timescale 1ns/1ps
// memory_responder: slave end of the req/ack memory link. Accepts one
// request at a time, services it against an internal word array after
// LATENCY cycles and answers with a single-cycle ack.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   req      master request, held until ack is observed
//   w_en     1 = write, 0 = read (valid while req is high)
//   addr     word address (valid while req is high)
//   ack      one-cycle completion pulse
//   data     bidirectional bus: write data in, read data out during ack
//   err      pulses with ack when addr >= MEM_DEPTH
//   busy     high from acceptance until the return to IDLE
module memory_responder #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 1024,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  ack,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  err,
   output logic                  busy
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_RECOVER
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;

   logic                  wr_q;
   logic                  oor_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  in_idle;
   logic                  accept;
   logic                  cur_wr;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_data;
   logic                  cur_in_range;
   logic [IDX_W-1:0]      cur_idx;
   logic                  commit;
   logic                  mem_we;
   logic                  rd_cap;
   logic                  drive_bus;

   assign in_idle = (state_q == S_IDLE);
   assign accept  = in_idle && req;

   // With LATENCY=1 the access commits on the acceptance edge itself,
   // before the request registers hold anything, so use the live inputs.
   assign cur_wr   = in_idle ? w_en : wr_q;
   assign cur_addr = in_idle ? addr : addr_q;
   assign cur_data = in_idle ? data : wdata_q;

   assign cur_in_range = ({1'b0, cur_addr} < DEPTH_L);
   assign cur_idx      = cur_addr[IDX_W-1:0];

   // The access happens on the edge that enters ACK. Gating with reset_n
   // keeps an aborted transaction from touching the array.
   assign commit = reset_n && (state_d == S_ACK) && (state_q != S_ACK);
   assign mem_we = commit && cur_wr && cur_in_range;
   assign rd_cap = commit && !cur_wr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d   = LAT_M1;
               state_d = (LATENCY == 1) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_ACK: begin
            state_d = S_RECOVER;
         end
         S_RECOVER: begin
            // A still-high req must not start a second access.
            if (!req) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q   <= w_en;
            addr_q <= addr;
            oor_q  <= !cur_in_range;
         end
      end
   end

   // Storage and datapath registers carry no reset: array contents
   // survive reset, and the read word is only visible during ACK.
   always_ff @(posedge clk) begin
      if (reset_n && accept && w_en) begin
         wdata_q <= data;
      end
      if (mem_we) begin
         mem[cur_idx] <= cur_data;
      end
      if (rd_cap) begin
         rdata_q <= cur_in_range ? mem[cur_idx] : '0;
      end
   end

   always_comb begin
      ack       = 1'b0;
      err       = 1'b0;
      busy      = 1'b0;
      drive_bus = 1'b0;
      if (state_q != S_IDLE) begin
         busy = 1'b1;
      end
      if (state_q == S_ACK) begin
         ack       = 1'b1;
         err       = oor_q;
         drive_bus = !wr_q;
      end
   end

   assign data = drive_bus ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
`timescale 1ns/1ps
// Bench for memory_responder: a LATENCY=1 and a LATENCY=4 instance,
// directed requests with an ack scoreboard per instance.
module tb_memory_responder;

   localparam int DW    = 256;
   localparam int AW    = 16;
   localparam int DEPTH = 1024;

   localparam logic [DW-1:0] PAT  = {32{8'h0F}};
   localparam logic [DW-1:0] V_A5 = {32{8'hA5}};
   localparam logic [DW-1:0] V_3C = {32{8'h3C}};
   localparam logic [DW-1:0] V_C3 = {32{8'hC3}};
   localparam logic [DW-1:0] V_12 = {16{16'h1234}};
   localparam logic [DW-1:0] V_33 = {8{32'h3333_0003}};
   localparam logic [DW-1:0] V_55 = {8{32'h5555_0005}};
   localparam logic [DW-1:0] V_66 = {8{32'h6666_0006}};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails = 0;

   logic          req1 = 1'b0;
   logic          w1 = 1'b0;
   logic [AW-1:0] a1 = '0;
   logic          oe1 = 1'b1;
   logic [DW-1:0] d1 = PAT;
   wire  [DW-1:0] data1;
   logic          ack1;
   logic          err1;
   logic          busy1;

   logic          req4 = 1'b0;
   logic          w4 = 1'b0;
   logic [AW-1:0] a4 = '0;
   logic          oe4 = 1'b1;
   logic [DW-1:0] d4 = PAT;
   wire  [DW-1:0] data4;
   logic          ack4;
   logic          err4;
   logic          busy4;

   assign data1 = oe1 ? d1 : {DW{1'bz}};
   assign data4 = oe4 ? d4 : {DW{1'bz}};

   memory_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .MEM_DEPTH(DEPTH), .LATENCY(1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .req(req1),
      .w_en(w1), .addr(a1), .ack(ack1),
      .data(data1), .err(err1), .busy(busy1)
   );

   memory_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .MEM_DEPTH(DEPTH), .LATENCY(4)
   ) u_dut4 (
      .clk(clk), .reset_n(reset_n), .req(req4),
      .w_en(w4), .addr(a4), .ack(ack4),
      .data(data4), .err(err4), .busy(busy4)
   );

   typedef struct {
      int            cyc;
      logic          err;
      logic          rd;
      logic [DW-1:0] d;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   exp_t m1;
   exp_t m4;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (ack1) begin
            if (q1.size() == 0) begin
               chk("ack1_unexpected", DW'(ack1), '0);
            end else begin
               m1 = q1.pop_front();
               chk("ack1_cycle", DW'(cyc), DW'(m1.cyc));
               chk("err1", DW'(err1), DW'(m1.err));
               if (m1.rd) chk("rdata1", data1, m1.d);
            end
         end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
            chk("ack1_missing", DW'(ack1), DW'(1));
            void'(q1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (ack4) begin
            if (q4.size() == 0) begin
               chk("ack4_unexpected", DW'(ack4), '0);
            end else begin
               m4 = q4.pop_front();
               chk("ack4_cycle", DW'(cyc), DW'(m4.cyc));
               chk("err4", DW'(err4), DW'(m4.err));
               if (m4.rd) chk("rdata4", data4, m4.d);
            end
         end else if (q4.size() > 0 && q4[0].cyc < cyc) begin
            chk("ack4_missing", DW'(ack4), DW'(1));
            void'(q4.pop_front());
         end
      end
   end

   // Called just after a rising edge with u_dut1 idle.
   task automatic issue1(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd_exp,
                         input logic e_err, input int hold);
      exp_t e;
      req1 = 1'b1;
      w1   = wr;
      a1   = a;
      oe1  = 1'b1;
      d1   = wr ? wd : PAT;
      e.cyc = cyc + 1;
      e.err = e_err;
      e.rd  = !wr;
      e.d   = rd_exp;
      q1.push_back(e);
      @(negedge clk);
      chk("busy1_idle", DW'(busy1), '0);
      if (!wr) chk("bus1_before", data1, PAT);
      @(posedge clk); #1;
      w1 = !wr;
      a1 = ~a;
      d1 = ~d1;
      if (!wr) oe1 = 1'b0;
      @(negedge clk);
      chk("busy1_ack", DW'(busy1), DW'(1));
      @(posedge clk); #1;
      oe1 = 1'b1;
      d1  = PAT;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("busy1_held", DW'(busy1), DW'(1));
         @(posedge clk); #1;
      end
      req1 = 1'b0;
      @(negedge clk);
      chk("busy1_recover", DW'(busy1), DW'(1));
      if (!wr) chk("bus1_after", data1, PAT);
      @(posedge clk); #1;
      chk("busy1_done", DW'(busy1), '0);
   endtask

   // Called just after a rising edge with u_dut4 idle.
   task automatic issue4(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd_exp,
                         input logic e_err, output int acc);
      exp_t e;
      req4 = 1'b1;
      w4   = wr;
      a4   = a;
      oe4  = 1'b1;
      d4   = wr ? wd : PAT;
      e.cyc = cyc + 4;
      e.err = e_err;
      e.rd  = !wr;
      e.d   = rd_exp;
      q4.push_back(e);
      @(posedge clk); #1;
      acc = cyc;
      w4 = !wr;
      a4 = ~a;
      d4 = ~d4;
      if (!wr) oe4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("busy4_active", DW'(busy4), DW'(1));
         @(posedge clk); #1;
      end
      req4 = 1'b0;
      oe4  = 1'b1;
      d4   = PAT;
      @(negedge clk);
      chk("busy4_recover", DW'(busy4), DW'(1));
      @(posedge clk); #1;
      chk("busy4_done", DW'(busy4), '0);
   endtask

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog: sim time exceeded, got=timeout want=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   int t0;
   int t1;
   int t2;

   initial begin
      @(negedge clk);
      chk("rst_ack1", DW'(ack1), '0);
      chk("rst_err1", DW'(err1), '0);
      chk("rst_busy1", DW'(busy1), '0);
      chk("rst_bus1", data1, PAT);
      chk("rst_ack4", DW'(ack4), '0);
      chk("rst_busy4", DW'(busy4), '0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue1(1'b1, 16'h0000, V_12, '0, 1'b0, 0);
      issue1(1'b1, 16'h0010, V_A5, '0, 1'b0, 0);
      issue1(1'b0, 16'h0010, '0, V_A5, 1'b0, 0);
      issue1(1'b1, 16'h0020, V_3C, '0, 1'b0, 5);
      issue1(1'b0, 16'h0020, '0, V_3C, 1'b0, 0);
      issue1(1'b1, 16'd1024, '1, '0, 1'b1, 0);
      issue1(1'b0, 16'd1024, '0, '0, 1'b1, 0);
      issue1(1'b0, 16'h0000, '0, V_12, 1'b0, 0);
      issue1(1'b1, 16'd1023, V_C3, '0, 1'b0, 0);
      issue1(1'b0, 16'd1023, '0, V_C3, 1'b0, 0);

      req1 = 1'b1;
      w1   = 1'b0;
      a1   = 16'd1024;
      oe1  = 1'b1;
      d1   = PAT;
      @(posedge clk); #1;
      oe1  = 1'b0;
      req1 = 1'b0;
      #1;
      chk("ack1_pre_rst", DW'(ack1), DW'(1));
      chk("err1_pre_rst", DW'(err1), DW'(1));
      reset_n = 1'b0;
      oe1 = 1'b1;
      #1;
      chk("ack1_in_rst", DW'(ack1), '0);
      chk("err1_in_rst", DW'(err1), '0);
      chk("busy1_in_rst", DW'(busy1), '0);
      chk("bus1_in_rst", data1, PAT);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue1(1'b0, 16'h0010, '0, V_A5, 1'b0, 0);

      issue4(1'b1, 16'h0003, V_33, '0, 1'b0, t0);
      issue4(1'b0, 16'h0003, '0, V_33, 1'b0, t1);
      chk("period4", DW'(t1 - t0), DW'(6));
      issue4(1'b1, 16'h0005, V_55, '0, 1'b0, t2);

      req4 = 1'b1;
      w4   = 1'b1;
      a4   = 16'h0005;
      d4   = V_66;
      @(posedge clk); #1;
      req4 = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      d4 = PAT;
      #1;
      chk("busy4_in_rst", DW'(busy4), '0);
      chk("ack4_in_rst", DW'(ack4), '0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue4(1'b0, 16'h0005, '0, V_55, 1'b0, t2);

      repeat (3) @(posedge clk);
      #1;
      chk("q1_drained", DW'(q1.size()), '0);
      chk("q4_drained", DW'(q4.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Slave-side endpoint of the shared memory req/ack interface: accepts one request at a time from a master, services it against an internal word array after a programmable latency, and answers with a single-cycle `ack`. On reads it drives the bidirectional `data` bus only during the ack cycle; on writes it samples `data` at acceptance. It is the storage model and responder that matrix-operand fetch and result write-back masters talk to.

## Interface
- `DATA_WIDTH`, 256, word width and data bus width
- `ADDR_WIDTH`, 16, address bus width (word addresses)
- `MEM_DEPTH`, 1024, number of stored words, 1..2^ADDR_WIDTH
- `LATENCY`, 1, cycles from acceptance edge to `ack` high; must be ≥1
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  1  master request, level held until `ack` observed
- `w_en`  in  1  1 = write, 0 = read; valid while `req` high
- `addr`  in  ADDR_WIDTH  word address; valid while `req` high
- `ack`  out  1  one-cycle completion pulse
- `data`  inout  DATA_WIDTH  write data from master / read data from responder
- `err`  out  1  pulse coincident with `ack` when `addr` ≥ MEM_DEPTH
- `busy`  out  1  high from acceptance until return to IDLE

## Operation
- States: IDLE, WAIT, ACK, RECOVER.
- IDLE: on rising edge with `req`=1, latch `addr`, `w_en`, and (if write) `data` into request registers; load latency counter with LATENCY-1; go to ACK if LATENCY=1, else WAIT.
- WAIT: decrement counter each cycle; when counter reaches 0 go to ACK.
- ACK: `ack`=1 for exactly this cycle. Write: array[addr] updated on the edge entering ACK. Read: registered read word driven on `data`, output enable high only in ACK. Next state RECOVER.
- RECOVER: stay while `req`=1; go to IDLE on first edge with `req`=0. A still-high `req` is never accepted twice.
- Out-of-range (`addr` ≥ MEM_DEPTH): write dropped, read returns all-zeros, `err`=1 with `ack`.
- `w_en`, `addr`, `data` changes after acceptance are ignored.
- `data` is high-impedance in every state except ACK-on-read; it is never driven during writes.
- Array contents are not reset; reads of never-written in-range words return X in simulation.

## Timing
- Reset values (async, immediate): state IDLE, `ack`=0, `err`=0, `busy`=0, `data` released to Z, counter 0. Memory contents preserved.
- Acceptance at edge N (req sampled 1 in IDLE) → `ack` high during cycle N+LATENCY → N+LATENCY+1.
- `busy` rises after edge N, falls after the edge returning to IDLE.
- Minimum request spacing: acceptance, LATENCY cycles, ≥1 RECOVER cycle with `req`=0, then IDLE; back-to-back period = LATENCY+2 cycles.
- Read data valid on `data` for the same single cycle as `ack`; master samples at the edge ending ACK.
- Reset asserted mid-WAIT/ACK: transaction aborted, no ack, write not committed if reset precedes the commit edge, bus released same instant.
- `req` dropping during WAIT (protocol violation): transaction still completes and acks; RECOVER then exits immediately.

## Test plan
- Reset: assert `reset_n`=0 mid-ACK of a read → `ack`, `err`, `busy` 0 and `data` Z immediately; after release, first `req` is accepted normally.
- Write then read, LATENCY=1: write 0xA5..A5 to addr 0x0010, `ack` one cycle after acceptance; read 0x0010 → `ack` next cycle with `data`=0xA5..A5, `data` Z the cycle before and after.
- LATENCY=4: read addr 3 accepted at edge N → `ack` only in cycle N+4, `busy` high N+1..N+5; period with immediate re-request = 6 cycles.
- Held `req`: master keeps `req`=1 for 5 cycles after `ack` → exactly one ack; no second access until `req` low one cycle.
- Out-of-range, MEM_DEPTH=1024: write 0xFF..FF to addr 1024 → `ack`+`err`; read addr 1024 → `data`=0, `err`=1; read addr 0 unchanged.
- Boundary: write/read addr MEM_DEPTH-1 (1023) → data round-trips, `err`=0.
